hamming_scrub_ctrl: RTL and testbench
=====================================

Name: hamming_scrub_ctrl

Overview:
- Sequencer for the Hamming-protected 16-bit counter datapath (counter register plus stored parity).
- Gates the counter enable and periodically pauses counting to run a check (syndrome) pass.
- On a single-bit error it issues a correction and re-verifies; on a double-bit error, check timeout or exhausted retries it halts in a sticky fatal state.
- Sits between the host-level run control and the counter/parity datapath.

Parameters:
- SCRUB_PERIOD, 32: counting cycles between automatic checks; legal range 2..2^16.
- TIMEOUT, 8: maximum cycles waited for chk_done or corr_done; legal range ≥1.
- RETRY_MAX, 2: consecutive corrections allowed without a clean check.
- CORR_CNT_W, 8: width of the saturating corrected-error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- run  input  1  host request to count.
- force_scrub  input  1  request an immediate check; level-sampled.
- clr_fatal  input  1  one-cycle pulse; clears the fatal state.
- cnt_en  output  1  enable to the counter datapath.
- chk_req  output  1  one-cycle pulse; start a syndrome check.
- chk_done  input  1  check result valid; err_single and err_double are sampled with it.
- err_single  input  1  correctable error detected.
- err_double  input  1  uncorrectable error detected.
- corr_req  output  1  one-cycle pulse; write the corrected word back.
- corr_done  input  1  correction written.
- busy  output  1  high in CHECK or CORRECT.
- fatal  output  1  sticky error flag.
- fatal_code  output  2  00 none, 01 double error, 10 timeout, 11 retry exhausted.
- corr_cnt  output  CORR_CNT_W  saturating count of completed corrections.

Behaviour:
- Reset, asynchronous, active-low: state IDLE; cnt_en, chk_req, corr_req, busy, fatal = 0; fatal_code = 00; corr_cnt = 0; interval timer, wait timer and retry counter = 0.
- All outputs are registered. A transition decided in cycle N is visible in cycle N+1.
- IDLE:
  - cnt_en = 0.
  - force_scrub → CHECK; else run → COUNT.
  - force_scrub has priority over run.
- COUNT:
  - cnt_en = 1. The interval timer increments each cycle.
  - If the timer equals SCRUB_PERIOD-1 or force_scrub = 1 → CHECK and the timer clears.
  - Else if run = 0 → IDLE, timer held, not cleared.
  - Check beats run deassertion when both occur in the same cycle.
- CHECK:
  - On entry: cnt_en = 0 and chk_req = 1 for exactly one cycle. The wait timer clears.
  - The counter is stalled from the chk_req cycle onward; no count occurs during a check.
  - On chk_done:
    - err_double → FATAL, code 01. err_double wins if both error flags are set.
    - err_single → CORRECT.
    - Clean → retry counter clears; go to COUNT if run, else IDLE.
  - No chk_done within TIMEOUT cycles after chk_req → FATAL, code 10.
  - chk_done arriving in the same cycle as the timeout is honoured; completion wins.
- CORRECT:
  - On entry: corr_req = 1 for one cycle and the retry counter increments.
  - On corr_done: corr_cnt increments, saturating at all-ones. The state then returns to CHECK to verify.
  - On entry, if the retry counter already equals RETRY_MAX → FATAL, code 11, and no corr_req is issued.
  - corr_done timeout → FATAL, code 10.
- FATAL:
  - cnt_en = 0 and fatal = 1; fatal_code is held.
  - run and force_scrub are ignored.
  - clr_fatal → IDLE. This clears fatal, fatal_code, the interval timer and the retry counter. corr_cnt is kept.
- Handshake inputs arriving outside their waiting state (stray chk_done or corr_done) are ignored.
- Reset asserted mid-check or mid-correction aborts immediately to the reset values.

Decomposition:
- Package hamming_scrub_pkg holds:
  - state enum: IDLE, COUNT, CHECK, CORRECT, FATAL;
  - fatal-code localparams FC_NONE, FC_DOUBLE, FC_TIMEOUT, FC_RETRY;
  - a function returning the timer width via clog2.
- One sub-module, scrub_timeout_timer: a loadable down-counter with an expire flag, instantiated twice (interval and handshake wait).

Test Plan:
- Reset then run=1, responder always clean after 2 cycles → cnt_en high 32 cycles; chk_req pulse; cnt_en low for 3 cycles; counting resumes; corr_cnt = 0.
- Responder returns err_single on the first check and clean on the re-check → one corr_req pulse; corr_cnt = 1; return to COUNT; fatal = 0.
- Responder returns err_double → FATAL with fatal_code = 01 and cnt_en = 0. run stays 1 for 10 cycles with no change. clr_fatal pulse → IDLE then COUNT, with corr_cnt preserved.
- chk_done never asserted → fatal = 1, fatal_code = 10, exactly 8 cycles after the chk_req pulse.
- err_single returned on every check → two corr_req pulses, then FATAL with fatal_code = 11; corr_cnt = 2.
- force_scrub asserted in IDLE, and run dropped on the same cycle the interval expires → a check runs in both cases; the controller ends in IDLE.
- Reset asserted while in CHECK → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/hamming_scrub_pkg.sv
// Shared types and constants for the Hamming scrub controller.
// Provides the sequencer state encoding, fatal-code values and timer sizing.
package hamming_scrub_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    CHECK,
    CORRECT,
    FATAL
  } state_t;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_DOUBLE  = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;
  localparam logic [1:0] FC_RETRY   = 2'b11;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned timer_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scrub_timeout_timer.sv
// Loadable down-counter that stops at zero and flags expiry while it sits there.
// Used both for the scrub interval and for handshake wait limits.
module scrub_timeout_timer #(
  parameter int unsigned W         = 4,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expired
);

  logic [W-1:0] count_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= W'(RESET_VAL);
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/hamming_scrub_ctrl.sv
// Run/scrub sequencer for the Hamming-protected counter: gates counting, runs periodic
// syndrome checks, issues corrections and latches fatal conditions.
module hamming_scrub_ctrl
  import hamming_scrub_pkg::*;
#(
  parameter int unsigned SCRUB_PERIOD = 32,
  parameter int unsigned TIMEOUT      = 8,
  parameter int unsigned RETRY_MAX    = 2,
  parameter int unsigned CORR_CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  force_scrub,
  input  logic                  clr_fatal,
  output logic                  cnt_en,
  output logic                  chk_req,
  input  logic                  chk_done,
  input  logic                  err_single,
  input  logic                  err_double,
  output logic                  corr_req,
  input  logic                  corr_done,
  output logic                  busy,
  output logic                  fatal,
  output logic [1:0]            fatal_code,
  output logic [CORR_CNT_W-1:0] corr_cnt
);

  localparam int unsigned IVL_W   = timer_width(SCRUB_PERIOD);
  localparam int unsigned WAIT_W  = timer_width(TIMEOUT);
  localparam int unsigned RETRY_W = timer_width(RETRY_MAX + 1);

  state_t               state_q, state_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [1:0]           code_d;
  logic [CORR_CNT_W-1:0] corr_cnt_d;
  logic                 chk_req_d, corr_req_d;
  logic                 ivl_load, ivl_dec, ivl_expired;
  logic                 wait_load, wait_dec, wait_expired;

  // Interval timer holds the cycles remaining in the period: a full reload is "elapsed = 0".
  scrub_timeout_timer #(
    .W         (IVL_W),
    .RESET_VAL (SCRUB_PERIOD - 1)
  ) u_interval (
    .clk      (clk),
    .rst      (rst),
    .load     (ivl_load),
    .load_val (IVL_W'(SCRUB_PERIOD - 1)),
    .dec      (ivl_dec),
    .expired  (ivl_expired)
  );

  scrub_timeout_timer #(
    .W         (WAIT_W),
    .RESET_VAL (0)
  ) u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (wait_load),
    .load_val (WAIT_W'(TIMEOUT - 1)),
    .dec      (wait_dec),
    .expired  (wait_expired)
  );

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    code_d     = fatal_code;
    corr_cnt_d = corr_cnt;
    chk_req_d  = 1'b0;
    corr_req_d = 1'b0;
    ivl_load   = 1'b0;
    ivl_dec    = 1'b0;
    wait_load  = 1'b0;
    wait_dec   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (force_scrub)  state_d = CHECK;
        else if (run)     state_d = COUNT;
      end
      COUNT: begin
        if (ivl_expired || force_scrub) begin
          state_d  = CHECK;
          ivl_load = 1'b1;
        end else begin
          ivl_dec = 1'b1;
          if (!run) state_d = IDLE;
        end
      end
      CHECK: begin
        wait_dec = 1'b1;
        if (chk_done) begin
          if (err_double) begin
            state_d = FATAL;
            code_d  = FC_DOUBLE;
          end else if (err_single) begin
            if (retry_q == RETRY_W'(RETRY_MAX)) begin
              state_d = FATAL;
              code_d  = FC_RETRY;
            end else begin
              state_d = CORRECT;
              retry_d = retry_q + 1'b1;
            end
          end else begin
            retry_d = '0;
            state_d = run ? COUNT : IDLE;
          end
        end else if (wait_expired) begin
          state_d = FATAL;
          code_d  = FC_TIMEOUT;
        end
      end
      CORRECT: begin
        wait_dec = 1'b1;
        if (corr_done) begin
          if (corr_cnt != '1) corr_cnt_d = corr_cnt + 1'b1;
          state_d = CHECK;
        end else if (wait_expired) begin
          state_d = FATAL;
          code_d  = FC_TIMEOUT;
        end
      end
      FATAL: begin
        if (clr_fatal) begin
          state_d  = IDLE;
          code_d   = FC_NONE;
          retry_d  = '0;
          ivl_load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Request pulses and the wait window both start on entry to a waiting state.
    if (state_d == CHECK && state_q != CHECK) begin
      chk_req_d = 1'b1;
      wait_load = 1'b1;
    end
    if (state_d == CORRECT && state_q != CORRECT) begin
      corr_req_d = 1'b1;
      wait_load  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      retry_q    <= '0;
      cnt_en     <= 1'b0;
      chk_req    <= 1'b0;
      corr_req   <= 1'b0;
      busy       <= 1'b0;
      fatal      <= 1'b0;
      fatal_code <= FC_NONE;
      corr_cnt   <= '0;
    end else begin
      state_q    <= state_d;
      retry_q    <= retry_d;
      cnt_en     <= (state_d == COUNT);
      chk_req    <= chk_req_d;
      corr_req   <= corr_req_d;
      busy       <= (state_d == CHECK) || (state_d == CORRECT);
      fatal      <= (state_d == FATAL);
      fatal_code <= code_d;
      corr_cnt   <= corr_cnt_d;
    end
  end

endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// Directed bench for hamming_scrub_ctrl with a behavioural check/correct responder.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_hamming_scrub_ctrl;

  logic       clk = 1'b0;
  logic       rst, run, force_scrub, clr_fatal;
  logic       chk_done, err_single, err_double, corr_done;
  logic       cnt_en, chk_req, corr_req, busy, fatal;
  logic [1:0] fatal_code;
  logic [7:0] corr_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Responder behaviour: 0 clean, 1 single error, 2 double error, 3 never answers.
  int resp_mode   = 0;
  int single_left = 0;
  int n_chk       = 0;
  int n_corr      = 0;
  int cp          = 0;
  int rp          = 0;

  hamming_scrub_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .force_scrub (force_scrub),
    .clr_fatal   (clr_fatal),
    .cnt_en      (cnt_en),
    .chk_req     (chk_req),
    .chk_done    (chk_done),
    .err_single  (err_single),
    .err_double  (err_double),
    .corr_req    (corr_req),
    .corr_done   (corr_done),
    .busy        (busy),
    .fatal       (fatal),
    .fatal_code  (fatal_code),
    .corr_cnt    (corr_cnt)
  );

  always #5 clk = ~clk;

  // Answers each request two cycles after the request pulse.
  initial begin
    chk_done = 1'b0; err_single = 1'b0; err_double = 1'b0; corr_done = 1'b0;
    forever begin
      @(negedge clk);
      chk_done = 1'b0; err_single = 1'b0; err_double = 1'b0; corr_done = 1'b0;
      if (chk_req) begin
        n_chk++;
        cp = 2;
      end else if (cp > 0) begin
        cp--;
        if (cp == 0 && resp_mode != 3) begin
          chk_done = 1'b1;
          if (single_left > 0) begin
            err_single = 1'b1;
            single_left--;
          end else if (resp_mode == 1) begin
            err_single = 1'b1;
          end else if (resp_mode == 2) begin
            err_double = 1'b1;
          end
        end
      end
      if (corr_req) begin
        n_corr++;
        rp = 2;
      end else if (rp > 0) begin
        rp--;
        if (rp == 0) corr_done = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return cnt_en;
      1:       return chk_req;
      2:       return busy;
      default: return fatal;
    endcase
  endfunction

  // Waits until the selected output reaches val; returns cycles waited.
  task automatic wait_for(input int sel, input logic val, input int limit,
                          input string name, output int cycles);
    cycles = 0;
    while (sig(sel) !== val && cycles < limit) begin
      tick();
      cycles++;
    end
    if (sig(sel) !== val) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no event within %0d cycles", name, limit);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; run = 1'b0; force_scrub = 1'b0; clr_fatal = 1'b0;
    tick(3);
    n_cmp++;
    if ({cnt_en, chk_req, corr_req, busy, fatal} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b expected 00000", {cnt_en, chk_req, corr_req, busy, fatal});
    end
    n_cmp++;
    if (fatal_code !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_code: got %b expected 00", fatal_code);
    end
    n_cmp++;
    if (corr_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_corr_cnt: got %0d expected 0", corr_cnt);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_scrub_clean();
    int c, hi, lo;
    run = 1'b1;
    wait_for(0, 1'b1, 10, "clean_start", c);
    hi = 0;
    while (cnt_en === 1'b1 && hi < 100) begin
      hi++;
      tick();
    end
    n_cmp++;
    if (hi !== 32) begin
      n_bad++;
      $display("FAIL clean_period: cnt_en high %0d cycles, expected 32", hi);
    end
    n_cmp++;
    if ({chk_req, busy} !== 2'b11) begin
      n_bad++;
      $display("FAIL clean_chk_req: chk_req,busy=%b expected 11", {chk_req, busy});
    end
    lo = 0;
    while (cnt_en === 1'b0 && lo < 50) begin
      lo++;
      tick();
    end
    n_cmp++;
    if (lo !== 3) begin
      n_bad++;
      $display("FAIL clean_stall: cnt_en low %0d cycles, expected 3", lo);
    end
    n_cmp++;
    if (n_chk !== 1 || corr_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL clean_counts: checks=%0d corr_cnt=%0d expected 1 and 0", n_chk, corr_cnt);
    end
  endtask

  task automatic test_single_correct();
    int c, s_chk, s_corr;
    single_left = 1;
    s_chk = n_chk; s_corr = n_corr;
    wait_for(1, 1'b1, 100, "single_chk_req", c);
    wait_for(0, 1'b1, 40, "single_resume", c);
    n_cmp++;
    if (c !== 9) begin
      n_bad++;
      $display("FAIL single_latency: resumed after %0d cycles, expected 9", c);
    end
    n_cmp++;
    if (n_corr - s_corr !== 1 || n_chk - s_chk !== 2) begin
      n_bad++;
      $display("FAIL single_pulses: corr_req=%0d chk_req=%0d expected 1 and 2",
               n_corr - s_corr, n_chk - s_chk);
    end
    n_cmp++;
    if (corr_cnt !== 8'd1 || fatal !== 1'b0) begin
      n_bad++;
      $display("FAIL single_result: corr_cnt=%0d fatal=%b expected 1 and 0", corr_cnt, fatal);
    end
  endtask

  task automatic test_double_fatal();
    int c, s_chk;
    resp_mode = 2;
    wait_for(1, 1'b1, 100, "double_chk_req", c);
    wait_for(3, 1'b1, 20, "double_fatal", c);
    n_cmp++;
    if (c !== 3 || fatal_code !== 2'b01) begin
      n_bad++;
      $display("FAIL double_entry: after %0d cycles code=%b expected 3 and 01", c, fatal_code);
    end
    force_scrub = 1'b1;
    s_chk = n_chk;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if ({fatal, fatal_code, cnt_en, busy} !== 5'b10100) begin
        n_bad++;
        $display("FAIL double_hold[%0d]: fatal,code,cnt_en,busy=%b expected 10100",
                 i, {fatal, fatal_code, cnt_en, busy});
      end
    end
    n_cmp++;
    if (n_chk !== s_chk) begin
      n_bad++;
      $display("FAIL double_ignore_force: %0d checks issued in FATAL, expected 0", n_chk - s_chk);
    end
    force_scrub = 1'b0; resp_mode = 0;
    clr_fatal = 1'b1;
    tick();
    clr_fatal = 1'b0;
    n_cmp++;
    if ({fatal, fatal_code, cnt_en} !== 4'b0000) begin
      n_bad++;
      $display("FAIL double_clear: fatal,code,cnt_en=%b expected 0000", {fatal, fatal_code, cnt_en});
    end
    tick();
    n_cmp++;
    if (cnt_en !== 1'b1 || corr_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL double_restart: cnt_en=%b corr_cnt=%0d expected 1 and 1", cnt_en, corr_cnt);
    end
  endtask

  task automatic test_timeout();
    int c;
    resp_mode = 3;
    wait_for(1, 1'b1, 100, "timeout_chk_req", c);
    wait_for(3, 1'b1, 30, "timeout_fatal", c);
    n_cmp++;
    if (c !== 8 || fatal_code !== 2'b10) begin
      n_bad++;
      $display("FAIL timeout_entry: fatal after %0d cycles code=%b expected 8 and 10", c, fatal_code);
    end
    resp_mode = 0;
    clr_fatal = 1'b1;
    tick();
    clr_fatal = 1'b0;
    tick();
    n_cmp++;
    if (fatal !== 1'b0 || cnt_en !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_clear: fatal=%b cnt_en=%b expected 0 and 1", fatal, cnt_en);
    end
  endtask

  task automatic test_retry_exhaust();
    int c, s_chk, s_corr;
    logic [7:0] s_cnt;
    resp_mode = 1;
    s_chk = n_chk; s_corr = n_corr; s_cnt = corr_cnt;
    wait_for(1, 1'b1, 100, "retry_chk_req", c);
    wait_for(3, 1'b1, 60, "retry_fatal", c);
    n_cmp++;
    if (c !== 15 || fatal_code !== 2'b11) begin
      n_bad++;
      $display("FAIL retry_entry: fatal after %0d cycles code=%b expected 15 and 11", c, fatal_code);
    end
    n_cmp++;
    if (n_corr - s_corr !== 2 || n_chk - s_chk !== 3) begin
      n_bad++;
      $display("FAIL retry_pulses: corr_req=%0d chk_req=%0d expected 2 and 3",
               n_corr - s_corr, n_chk - s_chk);
    end
    n_cmp++;
    if (corr_cnt !== s_cnt + 8'd2) begin
      n_bad++;
      $display("FAIL retry_corr_cnt: got %0d expected %0d", corr_cnt, s_cnt + 8'd2);
    end
    resp_mode = 0; run = 1'b0;
    clr_fatal = 1'b1;
    tick();
    clr_fatal = 1'b0;
    tick();
    n_cmp++;
    if (fatal !== 1'b0 || cnt_en !== 1'b0) begin
      n_bad++;
      $display("FAIL retry_clear: fatal=%b cnt_en=%b expected 0 and 0", fatal, cnt_en);
    end
  endtask

  task automatic test_force_idle();
    int c, s_chk;
    s_chk = n_chk;
    force_scrub = 1'b1;
    tick();
    force_scrub = 1'b0;
    n_cmp++;
    if ({chk_req, busy, cnt_en} !== 3'b110) begin
      n_bad++;
      $display("FAIL force_entry: chk_req,busy,cnt_en=%b expected 110", {chk_req, busy, cnt_en});
    end
    wait_for(2, 1'b0, 20, "force_done", c);
    n_cmp++;
    if (c !== 3) begin
      n_bad++;
      $display("FAIL force_latency: busy for %0d cycles, expected 3", c);
    end
    tick(3);
    n_cmp++;
    if (cnt_en !== 1'b0 || n_chk - s_chk !== 1) begin
      n_bad++;
      $display("FAIL force_idle: cnt_en=%b checks=%0d expected 0 and 1", cnt_en, n_chk - s_chk);
    end
  endtask

  task automatic test_run_drop_on_expire();
    int c;
    run = 1'b1;
    wait_for(0, 1'b1, 10, "drop_start", c);
    tick(31);
    n_cmp++;
    if (cnt_en !== 1'b1 || chk_req !== 1'b0) begin
      n_bad++;
      $display("FAIL drop_last_count: cnt_en=%b chk_req=%b expected 1 and 0", cnt_en, chk_req);
    end
    run = 1'b0;
    tick();
    n_cmp++;
    if (chk_req !== 1'b1 || cnt_en !== 1'b0) begin
      n_bad++;
      $display("FAIL drop_check_wins: chk_req=%b cnt_en=%b expected 1 and 0", chk_req, cnt_en);
    end
    wait_for(2, 1'b0, 20, "drop_done", c);
    tick(3);
    n_cmp++;
    if (cnt_en !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL drop_idle: cnt_en=%b busy=%b expected 0 and 0", cnt_en, busy);
    end
  endtask

  task automatic test_reset_mid_check();
    resp_mode = 3;
    force_scrub = 1'b1;
    tick();
    force_scrub = 1'b0;
    tick(2);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_in_check: busy=%b expected 1", busy);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({cnt_en, chk_req, corr_req, busy, fatal, fatal_code} !== 7'b0) begin
      n_bad++;
      $display("FAIL midreset_flags: got %b expected 0000000",
               {cnt_en, chk_req, corr_req, busy, fatal, fatal_code});
    end
    n_cmp++;
    if (corr_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL midreset_corr_cnt: got %0d expected 0", corr_cnt);
    end
    tick();
    rst = 1'b1;
    resp_mode = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_scrub_clean();
    test_single_correct();
    test_double_fatal();
    test_timeout();
    test_retry_exhaust();
    test_force_idle();
    test_run_drop_on_expire();
    test_reset_mid_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
